// File: rtl/multi_channel_clock_divider.sv
// Multi-channel programmable clock/strobe divider with shadowed runtime configuration.
// New divisor/mode settings are applied only at a period boundary, a disable or a sync.
module multi_channel_clock_divider #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEFAULT_DIV  = 5000,
    parameter int unsigned DEFAULT_MODE = 0,
    localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    input  logic              cfg_valid,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [WIDTH-1:0]  cfg_div,
    input  logic              cfg_mode,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] cfg_pending,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [WIDTH-1:0] RST_DIV  = WIDTH'(DEFAULT_DIV);
    localparam logic             RST_MODE = 1'(DEFAULT_MODE);

    logic [WIDTH-1:0]  r_cnt    [NUM_CH];
    logic [WIDTH-1:0]  r_div    [NUM_CH];
    logic [WIDTH-1:0]  r_sh_div [NUM_CH];
    logic [NUM_CH-1:0] r_mode;
    logic [NUM_CH-1:0] r_sh_mode;
    logic [NUM_CH-1:0] r_pend;
    logic [NUM_CH-1:0] r_clk_out;
    logic [NUM_CH-1:0] r_tick;
    logic              r_cfg_err;

    logic              w_cfg_ok;
    logic [NUM_CH-1:0] w_wr;
    logic [NUM_CH-1:0] w_term;

    assign w_cfg_ok = cfg_valid && (cfg_div != '0) && (32'(cfg_ch) < NUM_CH);

    // Per-channel write decode and full-width terminal compare (divisor is never 0).
    always_comb begin
        w_wr   = '0;
        w_term = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_wr[i]   = w_cfg_ok && (32'(cfg_ch) == 32'(i));
            w_term[i] = (r_cnt[i] == (r_div[i] - WIDTH'(1)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_err <= 1'b0;
            r_mode    <= {NUM_CH{RST_MODE}};
            r_sh_mode <= '0;
            r_pend    <= '0;
            r_clk_out <= '0;
            r_tick    <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_cnt[i]    <= '0;
                r_div[i]    <= RST_DIV;
                r_sh_div[i] <= '0;
            end
        end else begin
            r_cfg_err <= cfg_valid && !w_cfg_ok;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (!ch_en[i] || sync) begin
                    // Idle or phase restart: no tick, output low, pending config lands now.
                    r_cnt[i]     <= '0;
                    r_clk_out[i] <= 1'b0;
                    r_tick[i]    <= 1'b0;
                    if (r_pend[i]) begin
                        r_div[i]  <= r_sh_div[i];
                        r_mode[i] <= r_sh_mode[i];
                        r_pend[i] <= 1'b0;
                    end
                end else if (w_term[i]) begin
                    r_cnt[i]  <= '0;
                    r_tick[i] <= 1'b1;
                    if (r_pend[i]) begin
                        r_div[i]     <= r_sh_div[i];
                        r_mode[i]    <= r_sh_mode[i];
                        r_pend[i]    <= 1'b0;
                        r_clk_out[i] <= 1'b0;
                    end else begin
                        r_clk_out[i] <= r_mode[i] ? 1'b1 : ~r_clk_out[i];
                    end
                end else begin
                    r_cnt[i]     <= r_cnt[i] + WIDTH'(1);
                    r_tick[i]    <= 1'b0;
                    r_clk_out[i] <= r_mode[i] ? 1'b0 : r_clk_out[i];
                end
                // A same-edge write lands after any application, so it stays pending.
                if (w_wr[i]) begin
                    r_sh_div[i]  <= cfg_div;
                    r_sh_mode[i] <= cfg_mode;
                    r_pend[i]    <= 1'b1;
                end
            end
        end
    end

    assign cfg_err     = r_cfg_err;
    assign cfg_pending = r_pend;
    assign clk_out     = r_clk_out;
    assign tick        = r_tick;

endmodule

// File: doc/multi_channel_clock_divider.md
Name: multi_channel_clock_divider

Overview:
- NUM_CH-channel programmable divider that generates slow clocks and strobes from the system clock, e.g. display-refresh, debounce and scan timing.
- Each channel has a runtime divisor and mode (square clock or one-cycle tick).
- Configuration changes take effect glitch-free, only at a period boundary.
- A global sync input realigns the phase of all channels.

Parameters:
NUM_CH, 4, number of independent divider channels (1..16).
WIDTH, 32, bit width of the divisor and of each channel counter.
DEFAULT_DIV, 5000, divisor loaded into every channel at reset (must be >= 1).
DEFAULT_MODE, 0, mode loaded at reset: 0 = square, 1 = pulse.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  reset, synchronous, active-high.
ch_en  in  NUM_CH  per-channel enable.
sync  in  1  single-cycle request to restart the phase of all channels.
cfg_valid  in  1  configuration write strobe.
cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel of the write.
cfg_div  in  WIDTH  new divisor D (legal range 1..2^WIDTH-1).
cfg_mode  in  1  new mode.
cfg_err  out  1  one-cycle pulse: the write was rejected.
cfg_pending  out  NUM_CH  channel holds a shadow config that is not yet applied.
clk_out  out  NUM_CH  divided clock outputs (registered).
tick  out  NUM_CH  one-cycle terminal-count strobes (registered).

Behaviour:
- Reset: every output and internal register is updated on the clk edge where rst=1.
  - All counters = 0.
  - Active div = DEFAULT_DIV, active mode = DEFAULT_MODE.
  - Shadow registers cleared; cfg_pending = 0.
  - clk_out = 0, tick = 0, cfg_err = 0.
  - Reset asserted mid-period discards the partial period and any pending config.
- Counting (enabled channel):
  - Counter runs 0..D-1. At count == D-1 it wraps to 0 (the terminal cycle).
  - tick is registered from the terminal condition, so it is high for exactly one clk cycle after each terminal edge.
  - Period is D cycles. D = 1 gives tick high continuously.
- Square mode (0):
  - clk_out toggles on each terminal edge.
  - Output period is 2*D cycles at 50% duty; D = 1 gives clk/2.
  - The first rising edge of clk_out occurs D cycles after reset release or enable.
- Pulse mode (1):
  - clk_out equals tick: high 1 cycle in every D cycles.
- Disable (ch_en[i] = 0):
  - Counter held at 0; clk_out[i] = 0 and tick[i] = 0 on the next edge.
  - A pending config is applied immediately.
  - On re-enable, counting starts from 0, so the first terminal comes D cycles later.
- Configuration:
  - A write is accepted when cfg_valid = 1, cfg_div != 0 and cfg_ch < NUM_CH. It loads the shadow register of cfg_ch and sets cfg_pending[cfg_ch].
  - A second write before application overwrites the shadow (last writer wins).
  - Otherwise the write is rejected: cfg_err pulses on the next cycle and no state changes.
- Application of a shadow config to the active div/mode happens at:
  - the channel's terminal edge (the next period uses the new values), or
  - a disable, or
  - sync.
  - On application, cfg_pending clears and clk_out is forced to 0, so a mode change never produces a runt pulse.
- Simultaneous events:
  - Write and terminal on the same edge: the terminal uses the old config. The new config stays pending until the following terminal.
  - sync and terminal on the same edge: sync wins. Counters go to 0, clk_out = 0, no tick is generated, and pending configs are applied.
  - sync while disabled: the channel stays idle.
- Width:
  - The counter compare uses the full WIDTH. A divisor of 2^WIDTH-1 must never overflow.
  - No truncation anywhere.

Test Plan:
- Reset defaults with DEFAULT_DIV = 4, mode 0, ch_en = all 1 -> clk_out[0] rises 4 cycles after rst release; period 8, duty 4/4; tick pulses every 4 cycles.
- Write ch1 D = 3, mode 1, mid-period -> cfg_pending[1] = 1 until ch1's next terminal, then clears; ticks then occur every 3 cycles with clk_out[1] == tick[1]; other channels are undisturbed.
- Write with cfg_div = 0, and a write with cfg_ch = NUM_CH (NUM_CH = 3) -> cfg_err high for 1 cycle each; no pending bit set; outputs unchanged.
- Channels set to D = 5 and D = 7, then sync pulsed -> both counters at 0, clk_out = 0, and their next ticks occur exactly 5 and 7 cycles after sync; sync coinciding with a terminal produces no tick.
- D = 1 in both modes -> square gives clk/2 toggling every cycle; pulse gives tick held high; disabling mid-run drives outputs to 0 on the next edge.
- rst asserted for one cycle mid-period with a pending write present -> pending cleared, all outputs 0, DEFAULT_DIV restored; D = 2^WIDTH-1 with WIDTH = 8 gives a 255-cycle tick period.
